// File: rtl/c499_key_loader.sv
// c499_key_loader: serial key-provisioning front end for the key-locked c499 core.
// A frame arrives bit-serially over a valid/ready handshake. It carries KEY_W key bits,
// LSB first, followed by an 8-bit CRC sent MSB first. The key is committed to the held
// register only when the CRC matches.
// Optional feature macro: C499_KEY_LOCKOUT_EN. When it is defined, MAX_FAIL consecutive
// CRC failures lock the loader out until reset.
module c499_key_loader #(
    parameter int KEY_W    = 23,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_start,
    input  logic             key_valid,
    input  logic             key_sdi,
    output logic             key_ready,
    output logic [KEY_W-1:0] key_q,
    output logic             key_ok,
    output logic             key_err,
    output logic             locked
);

    localparam int FRAME_LEN = KEY_W + 8;
    localparam int CNT_W     = $clog2(FRAME_LEN);

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_LEN - 1);

`ifdef C499_KEY_LOCKOUT_EN
    localparam logic [3:0] FAIL_LAST = 4'(MAX_FAIL - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CHECK
`ifdef C499_KEY_LOCKOUT_EN
        ,
        LOCKOUT
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic [7:0]       crc_q, crc_d;
    logic [7:0]       rxCrc_q, rxCrc_d;
    logic [KEY_W-1:0] shiftReg_q, shiftReg_d;
    logic [KEY_W-1:0] keyHeld_q, keyHeld_d;
    logic             keyOk_q, keyOk_d;
    logic             keyErr_q, keyErr_d;
`ifdef C499_KEY_LOCKOUT_EN
    logic [3:0]       failCnt_q, failCnt_d;
`endif

    logic             transfer;
    logic             crcFb;
    logic [7:0]       crcNext;

    assign key_ready = (state_q == LOAD);
    assign transfer  = key_valid && key_ready;
    assign key_q     = keyHeld_q;
    assign key_ok    = keyOk_q;
    assign key_err   = keyErr_q;
`ifdef C499_KEY_LOCKOUT_EN
    assign locked    = (state_q == LOCKOUT);
`else
    assign locked    = 1'b0;
`endif

    // Advance the CRC-8 (poly 0x07) by one incoming key bit
    always_comb begin
        crcFb   = crc_q[7] ^ key_sdi;
        crcNext = {crc_q[6:0], 1'b0} ^ (crcFb ? 8'h07 : 8'h00);
    end

    // Next-state logic: frame reception, CRC verification, commit and lockout
    always_comb begin
        state_d    = state_q;
        bitCnt_d   = bitCnt_q;
        crc_d      = crc_q;
        rxCrc_d    = rxCrc_q;
        shiftReg_d = shiftReg_q;
        keyHeld_d  = keyHeld_q;
        keyOk_d    = keyOk_q;
        keyErr_d   = 1'b0;
`ifdef C499_KEY_LOCKOUT_EN
        failCnt_d  = failCnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (key_start) begin
                    state_d    = LOAD;
                    bitCnt_d   = '0;
                    crc_d      = '0;
                    rxCrc_d    = '0;
                    shiftReg_d = '0;
                end
            end

            LOAD: begin
                if (key_start) begin
                    bitCnt_d   = '0;
                    crc_d      = '0;
                    rxCrc_d    = '0;
                    shiftReg_d = '0;
                end else if (transfer) begin
                    if (bitCnt_q <= KEY_LAST) begin
                        shiftReg_d = {key_sdi, shiftReg_q[KEY_W-1:1]};
                        crc_d      = crcNext;
                    end else begin
                        rxCrc_d = {rxCrc_q[6:0], key_sdi};
                    end
                    if (bitCnt_q == FRAME_LAST) begin
                        state_d = CHECK;
                    end else begin
                        bitCnt_d = bitCnt_q + CNT_W'(1);
                    end
                end
            end

            CHECK: begin
                if (rxCrc_q == crc_q) begin
                    keyHeld_d = shiftReg_q;
                    keyOk_d   = 1'b1;
`ifdef C499_KEY_LOCKOUT_EN
                    failCnt_d = '0;
`endif
                    state_d   = IDLE;
                end else begin
                    keyErr_d = 1'b1;
`ifdef C499_KEY_LOCKOUT_EN
                    failCnt_d = failCnt_q + 4'd1;
                    if (failCnt_q == FAIL_LAST) begin
                        keyHeld_d = '0;
                        keyOk_d   = 1'b0;
                        state_d   = LOCKOUT;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end

`ifdef C499_KEY_LOCKOUT_EN
            LOCKOUT: begin
                keyHeld_d = '0;
                keyOk_d   = 1'b0;
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            crc_q      <= '0;
            rxCrc_q    <= '0;
            shiftReg_q <= '0;
            keyHeld_q  <= '0;
            keyOk_q    <= 1'b0;
            keyErr_q   <= 1'b0;
`ifdef C499_KEY_LOCKOUT_EN
            failCnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            crc_q      <= crc_d;
            rxCrc_q    <= rxCrc_d;
            shiftReg_q <= shiftReg_d;
            keyHeld_q  <= keyHeld_d;
            keyOk_q    <= keyOk_d;
            keyErr_q   <= keyErr_d;
`ifdef C499_KEY_LOCKOUT_EN
            failCnt_q  <= failCnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_c499_key_loader.sv
// tb_c499_key_loader: directed bench for c499_key_loader.
// The expected keys and CRCs are worked out by hand with CRC-8 poly 0x07, init 0:
//   0x000000 -> 0x00, 0x400000 -> 0x07, 0x600000 -> 0x09
// The lockout scenario follows C499_KEY_LOCKOUT_EN in the same way as the design.
module tb_c499_key_loader;

    logic        clk;
    logic        rst;
    logic        key_start;
    logic        key_valid;
    logic        key_sdi;
    logic        key_ready;
    logic [22:0] key_q;
    logic        key_ok;
    logic        key_err;
    logic        locked;

    int checkCount;
    int passCount;

    c499_key_loader #(
        .KEY_W    (23),
        .MAX_FAIL (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_start (key_start),
        .key_valid (key_valid),
        .key_sdi   (key_sdi),
        .key_ready (key_ready),
        .key_q     (key_q),
        .key_ok    (key_ok),
        .key_err   (key_err),
        .locked    (locked)
    );

    // 100 MHz free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if the observed value is wrong
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advances to just after the next rising edge
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Pulses key_start for one cycle; the loader must then be ready
    task automatic startFrame(input string tag);
        key_start = 1'b1;
        nextCycle();
        key_start = 1'b0;
        checkOutput({tag, "_ready"}, 32'(key_ready), 32'd1);
    endtask

    // Sends one bit, with up to maxGap idle cycles beforehand that carry junk data
    task automatic sendBit(input logic b, input int maxGap);
        int gap;
        gap = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
        repeat (gap) begin
            key_valid = 1'b0;
            key_sdi   = 1'($urandom_range(0, 1));
            nextCycle();
        end
        key_valid = 1'b1;
        key_sdi   = b;
        nextCycle();
        key_valid = 1'b0;
    endtask

    // Sends a whole frame: 23 key bits LSB first, then 8 CRC bits MSB first
    task automatic applyStimulus(input logic [22:0] key, input logic [7:0] crc,
                                 input int maxGap);
        for (int i = 0; i < 31; i++) begin
            if (i < 23) sendBit(key[i], maxGap);
            else        sendBit(crc[30-i], maxGap);
        end
    endtask

    // Checks the CHECK cycle and the result cycle, then checks that key_err falls again
    task automatic finishFrame(input string tag, input logic [22:0] expKey,
                               input logic expOk, input logic expErr,
                               input logic expLocked);
        checkOutput({tag, "_check_ready"}, 32'(key_ready), 32'd0);
        checkOutput({tag, "_check_err"}, 32'(key_err), 32'd0);
        nextCycle();
        checkOutput({tag, "_key"}, 32'(key_q), 32'(expKey));
        checkOutput({tag, "_ok"}, 32'(key_ok), 32'(expOk));
        checkOutput({tag, "_err"}, 32'(key_err), 32'(expErr));
        checkOutput({tag, "_locked"}, 32'(locked), 32'(expLocked));
        nextCycle();
        checkOutput({tag, "_err_fall"}, 32'(key_err), 32'd0);
    endtask

    // Directed scenario sequence
    initial begin
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        key_start  = 1'b0;
        key_valid  = 1'b0;
        key_sdi    = 1'b0;
        repeat (2) nextCycle();

        checkOutput("reset_ready", 32'(key_ready), 32'd0);
        checkOutput("reset_key", 32'(key_q), 32'd0);
        checkOutput("reset_ok", 32'(key_ok), 32'd0);
        checkOutput("reset_err", 32'(key_err), 32'd0);
        checkOutput("reset_locked", 32'(locked), 32'd0);
        rst = 1'b0;
        nextCycle();

        // A zero key with a zero CRC is committed
        startFrame("zero");
        applyStimulus(23'h000000, 8'h00, 0);
        finishFrame("zero", 23'h000000, 1'b1, 1'b0, 1'b0);

        // Only the last key bit set, then two adjacent bits set
        startFrame("k40");
        applyStimulus(23'h400000, 8'h07, 0);
        finishFrame("k40", 23'h400000, 1'b1, 1'b0, 1'b0);
        startFrame("k60");
        applyStimulus(23'h600000, 8'h09, 0);
        finishFrame("k60", 23'h600000, 1'b1, 1'b0, 1'b0);

        // Back-to-back: key_start in the first IDLE cycle after a result
        startFrame("b2b");
        applyStimulus(23'h400000, 8'h07, 0);
        checkOutput("b2b_check_ready", 32'(key_ready), 32'd0);
        nextCycle();
        checkOutput("b2b_key", 32'(key_q), 32'h400000);
        startFrame("b2b2");
        applyStimulus(23'h000000, 8'h00, 0);
        finishFrame("b2b2", 23'h000000, 1'b1, 1'b0, 1'b0);

        // A bad CRC leaves the committed key alone
        startFrame("good");
        applyStimulus(23'h400000, 8'h07, 0);
        finishFrame("good", 23'h400000, 1'b1, 1'b0, 1'b0);
        startFrame("bad");
        applyStimulus(23'h600000, 8'h07, 0);
        finishFrame("bad", 23'h400000, 1'b1, 1'b1, 1'b0);

        // A restart after 10 bits discards a transfer in the same cycle
        startFrame("base0");
        applyStimulus(23'h000000, 8'h00, 0);
        finishFrame("base0", 23'h000000, 1'b1, 1'b0, 1'b0);
        startFrame("rstrt");
        for (int i = 0; i < 10; i++) sendBit(1'(i % 2), 0);
        key_start = 1'b1;
        key_valid = 1'b1;
        key_sdi   = 1'b1;
        nextCycle();
        key_start = 1'b0;
        key_valid = 1'b0;
        checkOutput("rstrt_ready", 32'(key_ready), 32'd1);
        applyStimulus(23'h400000, 8'h07, 0);
        finishFrame("rstrt", 23'h400000, 1'b1, 1'b0, 1'b0);

        // Random stalls in key_valid do not disturb the frame
        startFrame("gap");
        applyStimulus(23'h600000, 8'h09, 3);
        finishFrame("gap", 23'h600000, 1'b1, 1'b0, 1'b0);

        // An asynchronous reset in the middle of LOAD
        startFrame("midrst");
        for (int i = 0; i < 5; i++) sendBit(1'b1, 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_ready", 32'(key_ready), 32'd0);
        checkOutput("midrst_key", 32'(key_q), 32'd0);
        checkOutput("midrst_ok", 32'(key_ok), 32'd0);
        checkOutput("midrst_locked", 32'(locked), 32'd0);
        nextCycle();
        rst = 1'b0;
        nextCycle();
        startFrame("fresh");
        applyStimulus(23'h400000, 8'h07, 0);
        finishFrame("fresh", 23'h400000, 1'b1, 1'b0, 1'b0);

        // Three consecutive bad-CRC frames
        startFrame("fail1");
        applyStimulus(23'h400000, 8'h00, 0);
        finishFrame("fail1", 23'h400000, 1'b1, 1'b1, 1'b0);
        startFrame("fail2");
        applyStimulus(23'h400000, 8'h00, 0);
        finishFrame("fail2", 23'h400000, 1'b1, 1'b1, 1'b0);
        startFrame("fail3");
        applyStimulus(23'h400000, 8'h00, 0);
`ifdef C499_KEY_LOCKOUT_EN
        finishFrame("fail3", 23'h000000, 1'b0, 1'b1, 1'b1);
        checkOutput("lock_ready", 32'(key_ready), 32'd0);
        key_start = 1'b1;
        nextCycle();
        key_start = 1'b0;
        checkOutput("lock_start_ready", 32'(key_ready), 32'd0);
        checkOutput("lock_start_locked", 32'(locked), 32'd1);
        checkOutput("lock_start_key", 32'(key_q), 32'd0);
`else
        finishFrame("fail3", 23'h400000, 1'b1, 1'b1, 1'b0);
        startFrame("retry");
        applyStimulus(23'h600000, 8'h09, 0);
        finishFrame("retry", 23'h600000, 1'b1, 1'b0, 1'b0);
`endif
        #2;
        rst = 1'b1;
        #1;
        checkOutput("final_rst_locked", 32'(locked), 32'd0);
        checkOutput("final_rst_key", 32'(key_q), 32'd0);
        nextCycle();
        rst = 1'b0;
        nextCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/c499_key_loader.md
# c499_key_loader

Serial key-provisioning stage that sits directly upstream of the key-locked c499 SEC core and drives its 23 key inputs (p1..p4, X_1..X_19). It accepts a key frame bit-serially over a valid/ready handshake, checks it against an appended CRC-8, and commits it to a held key register only on a CRC match. Repeated failures lock the loader out until reset.

## Interface
- KEY_W, 23, key bits per frame; key_q[3:0] = p1..p4, key_q[22:4] = X_1..X_19
- MAX_FAIL, 3, consecutive CRC failures that trigger lockout (1..15)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- key_start  in  1  single-cycle pulse that begins or restarts a frame
- key_valid  in  1  key_sdi is valid this cycle
- key_sdi  in  1  serial frame bit
- key_ready  out  1  loader will accept a bit this cycle
- key_q  out  KEY_W  committed key, held stable between commits
- key_ok  out  1  key_q holds a CRC-verified key
- key_err  out  1  one-cycle pulse on CRC mismatch
- locked  out  1  lockout active

## Operation
- Frame: KEY_W key bits, first accepted bit to shift-reg bit 0, then 8 CRC bits MSB first; total KEY_W+8 accepted bits.
- CRC-8: poly 0x07, init 0x00, serial over key bits only, in accept order: fb = crc[7]^bit; crc = {crc[6:0],0} ^ (fb ? 0x07 : 0).
- Transfer occurs when key_valid && key_ready; key_sdi ignored otherwise.
- FSM states:
  - IDLE: key_ready=0. key_start goes to LOAD with bit counter, CRC and shift regs cleared.
  - LOAD: key_ready=1. Counts transfers 0..KEY_W+7; after transfer KEY_W+7 goes to CHECK. key_start restarts the frame; counter, CRC and shift reg are cleared and a same-cycle transfer is discarded.
  - CHECK: one cycle, key_ready=0; compares received CRC to computed CRC.
    - Match: key_q<=shift reg, key_ok<=1, fail count<=0, go to IDLE.
    - Mismatch: key_err pulse, fail count+1. At MAX_FAIL go to LOCKOUT, otherwise IDLE. key_q and key_ok are unchanged.
  - LOCKOUT: key_ready=0, locked=1, key_q<=0, key_ok<=0. Ignores key_start; exits only on rst.
- key_q never changes except on commit, lockout or reset. There are no partial updates during LOAD.

## Timing
- Reset values: IDLE, key_ready=0, key_q=0, key_ok=0, key_err=0, locked=0, fail count 0.
- key_start in cycle T gives key_ready=1 from T+1.
- Final CRC bit accepted in cycle N. CHECK occupies N+1. key_q, key_ok, key_err and locked are visible in N+2.
- key_err is high for exactly one cycle (N+2).
- Back-to-back frames: key_start is accepted in the first IDLE cycle, N+2.
- rst asserted mid-LOAD or in LOCKOUT aborts immediately; all outputs return to reset values asynchronously.

## Configuration
- C499_KEY_LOCKOUT_EN defined: fail counter and LOCKOUT state are present as above.
- C499_KEY_LOCKOUT_EN undefined: no fail counter and no LOCKOUT state. A mismatch pulses key_err and returns to IDLE. Retries are unlimited, and locked is tied to 0.

## Test plan
- Reset, then frame key=0x000000 with CRC 0x00 -> key_q=0x000000, key_ok=1 at N+2, key_err=0.
- Frame key=0x400000 (only last key bit 1) with CRC 0x07 -> key_q=0x400000, key_ok=1. Then key=0x600000 with CRC 0x09 -> key_q=0x600000.
- Commit 0x400000, then send 0x600000 with CRC 0x07 -> key_err pulses for 1 cycle, key_q stays 0x400000, key_ok stays 1.
- With lockout enabled, three bad-CRC frames -> locked=1, key_q=0, key_ok=0, key_ready=0. A following key_start is ignored; rst clears locked.
- Issue key_start after 10 bits of a frame, then send a full valid 0x400000/0x07 frame -> commits 0x400000. Deassert key_valid for random cycles mid-frame -> same result.
- Assert rst mid-LOAD -> all outputs at reset values next cycle. A fresh frame then commits normally.
